// File: rtl/fret_event_arbiter.sv
// fret_event_arbiter
//
// Purpose:
//   Captures one-cycle press pulses from NLANES fret edge detectors as
//   pending requests and serializes them into one note-event stream using
//   a valid/ready handshake. The arbiter is round-robin by default. After
//   a lane's event is accepted, that lane ignores presses for LOCKOUT
//   cycles. Outside the game-play mode, the block stays flushed.
//
// Build option:
//   ARB_FIXED_PRIORITY_EN - when defined, IDLE always grants the lowest-index
//   pending lane, and the round-robin pointer is not built.
//
// Ports:
//   clk         system clock
//   n_rst       synchronous active-low reset
//   mode[2:0]   global game mode; the block is active when mode == ACTIVE_MODE
//   press[N]    one-cycle press pulses, one bit per lane
//   evt_ready   scorer accepts the offered event this cycle
//   evt_valid   event offered
//   evt_lane    lane index of the offered event
//   busy        any pending request, or an event on offer
//   drop_count  saturating count of presses lost to an already-pending lane
//
// States:
//   IDLE  | no event on offer; picks the next pending lane
//   OFFER | evt_valid high, evt_lane frozen until the handshake

module fret_event_arbiter #(
    parameter int  NLANES      = 4,
    parameter int  LOCKOUT     = 15,
    parameter int  ACTIVE_MODE = 4,
    localparam int LW          = $clog2(NLANES)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [2:0]        mode,
    input  logic [NLANES-1:0] press,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [LW-1:0]     evt_lane,
    output logic              busy,
    output logic [7:0]        drop_count
);

    localparam int             LCW       = (LOCKOUT > 1) ? $clog2(LOCKOUT + 1) : 1;
    localparam logic [LCW-1:0] LOCK_LOAD = LCW'(LOCKOUT);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t            state, state_d;
    logic [NLANES-1:0] pending, pending_d;
    logic [LCW-1:0]    lockout   [NLANES];
    logic [LCW-1:0]    lockout_d [NLANES];
    logic [LW-1:0]     lane_d, sel;
    logic [NLANES-1:0] hs_mask, capture, drop;
    logic              active, handshake, found;
    logic [3:0]        ndrops;
    logic [8:0]        drop_sum;
    logic [7:0]        drop_d;
`ifndef ARB_FIXED_PRIORITY_EN
    logic [LW-1:0]     rr, rr_d;
`endif

    assign evt_valid = (state == OFFER);
    assign busy      = (|pending) | evt_valid;

    // Lane selection from the registered pending bits only, so a press
    // captured in this cycle waits for the next IDLE evaluation.
`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel   = LW'(i);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NLANES; k++) begin
            logic [LW-1:0] idx;
            idx = LW'((int'(rr) + k) % NLANES);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        active    = (mode == 3'(ACTIVE_MODE));
        handshake = active && (state == OFFER) && evt_ready;
        hs_mask   = '0;
        if (handshake) begin
            hs_mask[evt_lane] = 1'b1;
        end

        // Capture. The lane being granted is treated as locked at the same edge
        // when a lockout exists. With no lockout, its pending bit is treated as
        // already cleared, so a press sets it again instead of being dropped.
        capture = '0;
        drop    = '0;
        ndrops  = '0;
        for (int i = 0; i < NLANES; i++) begin
            logic locked, held;
            locked = (lockout[i] != '0) || (hs_mask[i] && (LOCKOUT > 0));
            held   = pending[i] && !hs_mask[i];
            capture[i] = active && press[i] && !locked && !held;
            drop[i]    = active && press[i] && !locked && held;
            ndrops     = ndrops + {3'b000, drop[i]};
        end

        drop_sum = {1'b0, drop_count} + {5'b00000, ndrops};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

        pending_d = active ? ((pending & ~hs_mask) | capture) : '0;

        for (int i = 0; i < NLANES; i++) begin
            lockout_d[i] = '0;
            if (active) begin
                if (hs_mask[i]) begin
                    lockout_d[i] = LOCK_LOAD;
                end else if (lockout[i] != '0) begin
                    lockout_d[i] = lockout[i] - LCW'(1);
                end
            end
        end
    end

    // Next-state logic and datapath next values
    always_comb begin
        state_d = state;
        lane_d  = evt_lane;
`ifndef ARB_FIXED_PRIORITY_EN
        rr_d    = rr;
`endif
        if (!active) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state_d = OFFER;
                        lane_d  = sel;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        state_d = IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
                        rr_d    = evt_lane;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            evt_lane   <= '0;
            pending    <= '0;
            drop_count <= '0;
            for (int i = 0; i < NLANES; i++) begin
                lockout[i] <= '0;
            end
`ifndef ARB_FIXED_PRIORITY_EN
            rr         <= LW'(NLANES - 1);
`endif
        end else begin
            state      <= state_d;
            evt_lane   <= lane_d;
            pending    <= pending_d;
            drop_count <= drop_d;
            for (int i = 0; i < NLANES; i++) begin
                lockout[i] <= lockout_d[i];
            end
`ifndef ARB_FIXED_PRIORITY_EN
            rr         <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_fret_event_arbiter.sv
// Testbench for fret_event_arbiter. Inputs change one time unit after each
// rising edge. A request-level model predicts the registered outputs and
// the order of accepted events. A monitor checks the outputs on the
// falling edge and pops the expected lane for every handshake.

module tb_fret_event_arbiter;

    localparam int NL   = 4;
    localparam int LOCK = 15;
    localparam int ACT  = 4;

    logic          clk;
    logic          n_rst;
    logic [2:0]    mode;
    logic [NL-1:0] press;
    logic          evt_ready;
    logic          evt_valid;
    logic [1:0]    evt_lane;
    logic          busy;
    logic [7:0]    drop_count;

    fret_event_arbiter #(
        .NLANES      (NL),
        .LOCKOUT     (LOCK),
        .ACTIVE_MODE (ACT)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .mode       (mode),
        .press      (press),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_lane   (evt_lane),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: requests, lockout timers, the offered event, and counters.
    logic [NL-1:0] m_pend;
    int            m_lock [NL];
    logic          m_off;
    int            m_lane;
    int            m_rr;
    int            m_drops;
    int            exp_q[$];

    logic          chk_en = 1'b0;
    logic          exp_valid;
    logic [1:0]    exp_lane;
    logic          exp_busy;
    logic [7:0]    exp_drop;

    task automatic model_reset();
        m_pend  = '0;
        for (int i = 0; i < NL; i++) m_lock[i] = 0;
        m_off   = 1'b0;
        m_lane  = 0;
        m_rr    = NL - 1;
        m_drops = 0;
    endtask

    function automatic int pick_lane(input logic [NL-1:0] pend, input int rr);
        int r;
        r = -1;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = NL - 1; i >= 0; i--) if (pend[i]) r = i;
`else
        for (int k = NL; k >= 1; k--) if (pend[(rr + k) % NL]) r = (rr + k) % NL;
`endif
        return r;
    endfunction

    task automatic model_step(input logic [2:0] m, input logic [NL-1:0] p, input logic r);
        logic          hs;
        logic [NL-1:0] setm;
        if (m != 3'(ACT)) begin
            m_pend = '0;
            for (int i = 0; i < NL; i++) m_lock[i] = 0;
            m_off = 1'b0;
            return;
        end
        hs   = m_off && r;
        setm = '0;
        for (int i = 0; i < NL; i++) begin
            if (p[i]) begin
                if (m_lock[i] > 0 || (hs && m_lane == i && LOCK > 0)) begin
                    // locked out: ignored and not counted
                end else if (m_pend[i] && !(hs && m_lane == i)) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    setm[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NL; i++) if (m_lock[i] > 0) m_lock[i]--;
        if (hs) begin
            exp_q.push_back(m_lane);
            m_pend[m_lane] = 1'b0;
            m_lock[m_lane] = LOCK;
            m_rr  = m_lane;
            m_off = 1'b0;
        end else if (!m_off && m_pend != '0) begin
            m_lane = pick_lane(m_pend, m_rr);
            m_off  = 1'b1;
        end
        m_pend = m_pend | setm;
    endtask

    // One clock cycle: apply the inputs, record what the outputs must show in
    // this cycle, then advance the model across the next edge.
    task automatic step(input logic rst_n_i, input logic [2:0] m,
                        input logic [NL-1:0] p, input logic r);
        @(posedge clk);
        #1;
        n_rst     = rst_n_i;
        mode      = m;
        press     = p;
        evt_ready = r;
        exp_valid = m_off;
        exp_lane  = 2'(m_lane);
        exp_busy  = m_off || (m_pend != '0);
        exp_drop  = 8'(m_drops);
        chk_en    = 1'b1;
        if (!rst_n_i) model_reset();
        else model_step(m, p, r);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (evt_valid !== exp_valid) begin
                failures++;
                $display("FAIL evt_valid got=%0b exp=%0b t=%0t", evt_valid, exp_valid, $time);
            end
            checks++;
            if (evt_lane !== exp_lane) begin
                failures++;
                $display("FAIL evt_lane got=%0d exp=%0d t=%0t", evt_lane, exp_lane, $time);
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL busy got=%0b exp=%0b t=%0t", busy, exp_busy, $time);
            end
            checks++;
            if (drop_count !== exp_drop) begin
                failures++;
                $display("FAIL drop_count got=%0d exp=%0d t=%0t", drop_count, exp_drop, $time);
            end
        end
        if (n_rst === 1'b1 && mode == 3'(ACT) && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event_order unexpected event lane=%0d t=%0t", evt_lane, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(evt_lane) != e) begin
                    failures++;
                    $display("FAIL event_order got lane=%0d exp lane=%0d t=%0t", evt_lane, e, $time);
                end
            end
        end
    end

    logic [NL-1:0] rp;
    logic          rrst, rrdy;
    logic [2:0]    rm;

    initial begin
        n_rst     = 1'b0;
        mode      = 3'(ACT);
        press     = '0;
        evt_ready = 1'b0;
        model_reset();
        step(0, 4, 4'b0000, 0);
        step(0, 4, 4'b0000, 0);

        // Single press on lane 2
        step(1, 4, 4'b0100, 1);
        repeat (5) step(1, 4, 4'b0000, 1);

        // All lanes pressed at once
        step(0, 4, 4'b0000, 0);
        step(1, 4, 4'b1111, 1);
        repeat (12) step(1, 4, 4'b0000, 1);

        // Stall with repeated presses on lane 1
        step(0, 4, 4'b0000, 0);
        step(1, 4, 4'b0010, 0);
        step(1, 4, 4'b0000, 0);
        step(1, 4, 4'b0010, 0);
        step(1, 4, 4'b0000, 0);
        step(1, 4, 4'b0010, 0);
        repeat (4) step(1, 4, 4'b0000, 0);
        repeat (4) step(1, 4, 4'b0000, 1);

        // Lockout window on lane 0; handshake happens in the third cycle.
        step(0, 4, 4'b0000, 0);
        step(1, 4, 4'b0001, 1);
        step(1, 4, 4'b0000, 1);
        step(1, 4, 4'b0000, 1);
        repeat (4) step(1, 4, 4'b0000, 1);
        step(1, 4, 4'b0001, 1);
        repeat (10) step(1, 4, 4'b0000, 1);
        step(1, 4, 4'b0001, 1);
        repeat (5) step(1, 4, 4'b0000, 1);

        // Round-robin after granting lane 2
        step(0, 4, 4'b0000, 0);
        step(1, 4, 4'b0100, 0);
        step(1, 4, 4'b0000, 0);
        step(1, 4, 4'b1001, 0);
        step(1, 4, 4'b0000, 1);
        repeat (8) step(1, 4, 4'b0000, 1);

        // Mode exit while offering, then resume, then reset
        step(0, 4, 4'b0000, 0);
        step(1, 4, 4'b0010, 0);
        step(1, 4, 4'b0000, 0);
        step(1, 4, 4'b0010, 0);
        step(1, 2, 4'b0000, 0);
        step(1, 4, 4'b0000, 0);
        step(1, 4, 4'b0010, 1);
        repeat (4) step(1, 4, 4'b0000, 1);
        step(0, 4, 4'b0000, 0);
        step(1, 4, 4'b0000, 0);

        // drop_count saturation
        step(1, 4, 4'b1000, 0);
        repeat (300) step(1, 4, 4'b1000, 0);
        step(1, 4, 4'b0000, 1);
        repeat (3) step(1, 4, 4'b0000, 1);
        step(0, 4, 4'b0000, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rp = '0;
            for (int i = 0; i < NL; i++) if ($urandom_range(0, 5) == 0) rp[i] = 1'b1;
            rrst = ($urandom_range(0, 299) != 0);
            rm   = ($urandom_range(0, 59) == 0) ? 3'd2 : 3'(ACT);
            rrdy = ($urandom_range(0, 2) != 0);
            step(rrst, rm, rp, rrdy);
        end
        step(1, 4, 4'b0000, 1);
        step(1, 4, 4'b0000, 1);
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL event_queue leftover got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
